// File: rtl/modulo_varredura_matriz.sv
// Row-scan driver for the 5x7 LED clock display: latches a whole frame at frame
// start, then walks the rows with a blanking gap at the start of each row period.
module modulo_varredura_matriz #(
    parameter int ROW_TICKS   = 1000,
    parameter int BLANK_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [4:0] cl1,
    input  logic [4:0] cl2,
    input  logic [4:0] cl3,
    input  logic [4:0] cl4,
    input  logic [4:0] cl5,
    input  logic [4:0] cl6,
    input  logic [4:0] cl7,
    output logic [6:0] linhas,
    output logic [4:0] colunas,
    output logic [2:0] row_idx,
    output logic       frame_start
);

    localparam int TW = (ROW_TICKS > 1) ? $clog2(ROW_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(ROW_TICKS - 1);
    localparam logic [TW-1:0] TICK_BLANK = TW'(BLANK_TICKS);

    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    row_q, row_d;
    logic [4:0]    frame_q [7];
    logic [4:0]    frame_d [7];
    logic [4:0]    cl_w    [7];
    logic          blank_w;

    always_comb begin
        cl_w[0] = cl1;
        cl_w[1] = cl2;
        cl_w[2] = cl3;
        cl_w[3] = cl4;
        cl_w[4] = cl5;
        cl_w[5] = cl6;
        cl_w[6] = cl7;
    end

    // Reset wins over en, so no capture (and no pulse) can happen while rst is high.
    assign frame_start = en && !rst && (row_q == 3'd0) && (tick_q == '0);

    always_comb begin
        tick_d  = tick_q;
        row_d   = row_q;
        frame_d = frame_q;
        if (en) begin
            if (tick_q == TICK_LAST) begin
                tick_d = '0;
                row_d  = (row_q == 3'd6) ? 3'd0 : row_q + 3'd1;
            end else begin
                tick_d = tick_q + TW'(1);
            end
            if (frame_start) begin
                frame_d = cl_w;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
            row_q  <= '0;
            for (int r = 0; r < 7; r++) begin
                frame_q[r] <= '0;
            end
        end else begin
            tick_q  <= tick_d;
            row_q   <= row_d;
            frame_q <= frame_d;
        end
    end

    // Outputs depend only on registered state and en; the cl inputs reach the pins
    // exclusively through the frame buffer.
    assign blank_w = !en || (tick_q < TICK_BLANK);

    always_comb begin
        linhas  = 7'h7F;
        colunas = 5'b00000;
        if (!blank_w) begin
            linhas  = ~(7'd1 << row_q);
            colunas = frame_q[row_q];
        end
    end

    assign row_idx = row_q;

endmodule
